pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_hist.sv | 52 +++++
 rtl/pc_gen.sv | 111 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: FSM encoding and
// default datapath constants.
package pc_pkg;

   // RUN: no redirect waiting. PEND: a redirect arrived under stall and is held.
   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } pc_state_e;

   localparam int PC_WIDTH   = 32;
   localparam int PC_INC     = 4;
   // History count port width; wide enough for the largest legal depth (16).
   localparam int HIST_CNT_W = 5;

endpackage : pc_pkg

// File: rtl/pc_hist.sv
// Issued-PC history: a shift register of the most recent fetch addresses,
// newest in entry 0, with a saturating count of valid entries.
module pc_hist
   import pc_pkg::*;
#(
   parameter int WIDTH      = PC_WIDTH,
   parameter int HIST_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic                        clr_cnt,
   input  logic [WIDTH-1:0]            din,
   output logic [HIST_DEPTH*WIDTH-1:0] hist,
   output logic [HIST_CNT_W-1:0]       cnt
);

   localparam logic [HIST_CNT_W-1:0] CNT_MAX = HIST_CNT_W'(HIST_DEPTH);

   logic [WIDTH-1:0]      entry_q [HIST_DEPTH];
   logic [HIST_CNT_W-1:0] cnt_q;

   // Shift a newly issued PC in at entry 0; the oldest entry falls off the end.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: this is a handful of flops whose reset value is visible on the
         // ports, so every entry is reset; a RAM-style history would not be.
         for (int i = 0; i < HIST_DEPTH; i++) entry_q[i] <= '0;
      end else if (push) begin
         entry_q[0] <= din;
         for (int i = 1; i < HIST_DEPTH; i++) entry_q[i] <= entry_q[i-1];
      end
   end

   // Count valid entries; an exception clears the count but keeps the contents.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr_cnt) begin
         cnt_q <= '0;
      end else if (push && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 5'd1;
      end
   end

   for (genvar g = 0; g < HIST_DEPTH; g++) begin : g_pack
      assign hist[g*WIDTH +: WIDTH] = entry_q[g];
   end

   assign cnt = cnt_q;

endmodule : pc_hist

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch addresses with exception and
// branch redirects, a pending-redirect FSM for stalled pipelines, and an
// issued-PC history.
module pc_gen
   import pc_pkg::*;
#(
   parameter int          WIDTH      = PC_WIDTH,
   parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
   parameter int          INC        = PC_INC,
   parameter int          HIST_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        stall,
   input  logic                        redirect_valid,
   input  logic [WIDTH-1:0]            redirect_pc,
   input  logic                        exc_valid,
   input  logic [WIDTH-1:0]            exc_vec,
   input  logic                        fetch_ready,
   output logic                        fetch_valid,
   output logic [WIDTH-1:0]            pc,
   output logic [WIDTH-1:0]            pc_prev,
   output logic [HIST_DEPTH*WIDTH-1:0] hist_pc,
   output logic [HIST_CNT_W-1:0]       hist_cnt,
   output logic                        align_err
);

   localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
   localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);

   pc_state_e        state_q, state_nxt;
   logic [WIDTH-1:0] pc_q, pc_nxt;
   logic [WIDTH-1:0] pend_q, pend_nxt;
   logic             fv_q;
   logic             fire;
   logic             load;
   logic [WIDTH-1:0] tgt;

   assign fire = fv_q & fetch_ready & ~stall;

   // Next-PC selection, highest priority first: exception, live redirect,
   // stalled-redirect capture, pending redirect, sequential increment, hold.
   always_comb begin
      // NOTE: every output of this block gets a default here, so no path can
      // leave one unassigned and infer a latch.
      pc_nxt    = pc_q;
      state_nxt = state_q;
      pend_nxt  = pend_q;
      load      = 1'b0;
      tgt       = '0;
      if (exc_valid) begin
         load      = 1'b1;
         tgt       = exc_vec;
         state_nxt = RUN;
         pend_nxt  = '0;
      end else if (redirect_valid && !stall) begin
         load      = 1'b1;
         tgt       = redirect_pc;
         state_nxt = RUN;
      end else if (redirect_valid && stall) begin
         pend_nxt  = redirect_pc;
         state_nxt = PEND;
      end else if ((state_q == PEND) && !stall) begin
         load      = 1'b1;
         tgt       = pend_q;
         state_nxt = RUN;
      end else if (fire) begin
         pc_nxt    = pc_q + INC_W;
      end
      if (load) pc_nxt = {tgt[WIDTH-1:2], 2'b00};
   end

   // Misaligned targets are reported in the cycle the load is selected.
   assign align_err = rst & load & (|tgt[1:0]);

   // Architectural state: PC, FSM state, pending target, and the fetch-valid
   // flag that rises one cycle after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= RST_PC;
         state_q <= RUN;
         pend_q  <= '0;
         fv_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed by the combinational block.
         pc_q    <= pc_nxt;
         state_q <= state_nxt;
         pend_q  <= pend_nxt;
         fv_q    <= 1'b1;
      end
   end

   pc_hist #(
      .WIDTH      (WIDTH),
      .HIST_DEPTH (HIST_DEPTH)
   ) u_hist (
      .clk     (clk),
      .rst     (rst),
      .push    (fire),
      .clr_cnt (exc_valid),
      .din     (pc_q),
      .hist    (hist_pc),
      .cnt     (hist_cnt)
   );

   assign pc          = pc_q;
   assign pc_prev     = hist_pc[WIDTH-1:0];
   assign fetch_valid = fv_q;

endmodule : pc_gen
